fetch_prefetch_queue: RTL and testbench

- Instruction fetch stage directly upstream of the instruction register/decoder.
- Issues sequential word reads to program memory and buffers returned words with their PC in a small FIFO.
- Presents words to the decode stage over a valid/ready handshake.
- Supports PC redirect (branch/PC write) with flush of buffered and in-flight words.

---
 rtl/fetch_prefetch_queue.sv | 148 ++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential instruction prefetcher for the decode stage.
// Issues one word read per cycle to program memory (fixed 1-cycle latency),
// buffers returned words together with the PC they were fetched from in a
// small FIFO, and hands them to decode over a valid/ready handshake.
// A redirect flushes buffered and in-flight words and restarts at a new PC.
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     halt,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic [31:0]              mem_rdata,
    output logic                     ins_valid,
    output logic [31:0]              ins_data,
    output logic [31:0]              ins_pc,
    input  logic                     ins_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_FULL   = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     rsp_pc_q, rsp_pc_d;
    logic            inflight_q, inflight_d;
    logic            stale_q, stale_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]     data_q [DEPTH];
    logic [31:0]     data_d [DEPTH];
    logic [31:0]     pc_q   [DEPTH];
    logic [31:0]     pc_d   [DEPTH];

    logic [CW-1:0]   occupancy;
    logic            issue;
    logic            push;
    logic            pop;

    // Issue a read only when a FIFO slot is guaranteed for its response.
    always_comb begin
        occupancy = count_q + CW'(inflight_q);
        issue     = rst_n && (state_q != ST_FULL) && !halt && !redirect
                    && (occupancy < CW'(DEPTH));
    end

    // Next-state for fetch PC, response tracking, FIFO storage and state.
    always_comb begin
        push       = inflight_q && !stale_q && !redirect;
        pop        = (count_q != '0) && ins_ready;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = 1'b0;
        stale_d    = 1'b0;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
            pc_d[i]   = pc_q[i];
        end

        if (redirect) begin
            // Flush: the head popped this cycle is already consumed, and any
            // response landing now belongs to the abandoned stream.
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            stale_d    = inflight_q;
        end else begin
            if (push) begin
                data_d[wr_ptr_q] = mem_rdata;
                pc_d[wr_ptr_q]   = rsp_pc_q;
                wr_ptr_d         = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d    = count_q + CW'(push) - CW'(pop);
            inflight_d = issue;
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'(PC_STEP);
                rsp_pc_d   = fetch_pc_q;
            end
        end

        if (halt) begin
            state_d = ST_HALTED;
        end else if ((count_d + CW'(inflight_d)) == CW'(DEPTH)) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_FETCH;
        end
    end

    // State registers; reset drops every buffered and in-flight word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= '0;
            inflight_q <= 1'b0;
            stale_q    <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            stale_q    <= stale_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
                pc_q[i]   <= pc_d[i];
            end
        end
    end

    assign mem_req   = issue;
    assign mem_addr  = fetch_pc_q;
    assign ins_valid = (count_q != '0);
    assign ins_data  = data_q[rd_ptr_q];
    assign ins_pc    = pc_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Testbench for fetch_prefetch_queue: directed stimulus, a queue-based
// reference model compared every cycle, and literal spot checks.
module tb_fetch_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        ins_valid;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        ins_ready;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_prefetch_queue #(
        .DEPTH(DEPTH),
        .RESET_PC(RESET_PC),
        .PC_STEP(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .halt(halt),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .ins_valid(ins_valid),
        .ins_data(ins_data),
        .ins_pc(ins_pc),
        .ins_ready(ins_ready),
        .count(count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Program memory: answers one cycle after each request seen by the bench.
    logic        mreq_s  = 1'b0;
    logic [31:0] maddr_s = '0;
    always @(negedge clk) begin
        mreq_s  = mem_req;
        maddr_s = mem_addr;
    end
    always @(posedge clk) begin
        #1;
        mem_rdata = mreq_s ? mem_word(maddr_s) : 32'hDEAD_BEEF;
    end

    // Reference model: FIFO of fetched PCs, one optional pending response.
    logic [31:0] m_fifo[$];
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_fpc;
    int          m_occ;
    bit          m_exp_req;
    bit          m_exp_vld;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_fifo.delete();
            m_pend = 1'b0;
            m_pend_pc = '0;
            m_fpc = RESET_PC;
            check1("rst_mem_req", mem_req, 1'b0);
            check32("rst_mem_addr", mem_addr, RESET_PC);
            check1("rst_ins_valid", ins_valid, 1'b0);
            check32("rst_count", 32'(count), 32'd0);
            check32("rst_ins_data", ins_data, 32'd0);
            check32("rst_ins_pc", ins_pc, 32'd0);
        end else begin
            m_occ     = m_fifo.size() + int'(m_pend);
            m_exp_req = !halt && !redirect && (m_occ < DEPTH);
            m_exp_vld = (m_fifo.size() != 0);
            check1("mdl_mem_req", mem_req, m_exp_req);
            check32("mdl_mem_addr", mem_addr, m_fpc);
            check1("mdl_ins_valid", ins_valid, m_exp_vld);
            check32("mdl_count", 32'(count), 32'(m_fifo.size()));
            check1("count_le_depth", (32'(count) <= 32'(DEPTH)), 1'b1);
            if (m_exp_vld) begin
                check32("mdl_ins_pc", ins_pc, m_fifo[0]);
                check32("mdl_ins_data", ins_data, mem_word(m_fifo[0]));
            end
            if (m_exp_vld && ins_ready) void'(m_fifo.pop_front());
            if (m_pend && !redirect) m_fifo.push_back(m_pend_pc);
            if (redirect) begin
                m_fifo.delete();
                m_pend = 1'b0;
                m_fpc  = redirect_pc & ~32'd3;
            end else begin
                m_pend    = m_exp_req;
                m_pend_pc = m_fpc;
                if (m_exp_req) m_fpc = m_fpc + 32'd4;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
        ins_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        // Stream from reset
        check1("s1_req", mem_req, 1'b1);
        check32("s1_addr", mem_addr, 32'h0);
        check1("s1_vld", ins_valid, 1'b0);
        cyc(); #1;
        check32("s2_addr", mem_addr, 32'h4);
        check1("s2_vld", ins_valid, 1'b0);
        cyc(); #1;
        check1("s3_vld", ins_valid, 1'b1);
        check32("s3_pc", ins_pc, 32'h0);
        check32("s3_data", ins_data, 32'hA5A5_0000);
        cyc(); #1;
        check32("s4_pc", ins_pc, 32'h4);
        check32("s4_data", ins_data, 32'hA5A5_0004);
        check32("s4_count", 32'(count), 32'd1);
        repeat (6) cyc();

        // Backpressure from a fresh reset
        rst_n = 1'b0; ins_ready = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        repeat (10) cyc();
        #1;
        check32("bp_count", 32'(count), 32'd4);
        check1("bp_req", mem_req, 1'b0);
        check32("bp_addr", mem_addr, 32'h10);
        check32("bp_head", ins_pc, 32'h0);
        ins_ready = 1'b1;
        cyc(); #1;
        check32("bp_pc1", ins_pc, 32'h4);
        check32("bp_cnt1", 32'(count), 32'd3);
        check1("bp_req1", mem_req, 1'b1);
        check32("bp_addr1", mem_addr, 32'h10);
        cyc(); #1;
        check32("bp_pc2", ins_pc, 32'h8);
        check32("bp_addr2", mem_addr, 32'h14);

        // Redirect while the 0x14 request is in flight
        cyc();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        #1;
        check1("rd_r_req", mem_req, 1'b0);
        check32("rd_r_pc", ins_pc, 32'hC);
        cyc();
        redirect = 1'b0;
        #1;
        check1("rd_r1_req", mem_req, 1'b1);
        check32("rd_r1_addr", mem_addr, 32'h100);
        check32("rd_r1_count", 32'(count), 32'd0);
        check1("rd_r1_vld", ins_valid, 1'b0);
        cyc(); #1;
        check1("rd_r2_vld", ins_valid, 1'b0);
        check32("rd_r2_addr", mem_addr, 32'h104);
        cyc(); #1;
        check1("rd_r3_vld", ins_valid, 1'b1);
        check32("rd_r3_pc", ins_pc, 32'h100);
        check32("rd_r3_data", ins_data, 32'hA5A5_0100);
        repeat (3) cyc();

        // Address wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        #1 check1("wr_r_req", mem_req, 1'b0);
        cyc();
        redirect = 1'b0;
        #1;
        check1("wr_req1", mem_req, 1'b1);
        check32("wr_addr1", mem_addr, 32'hFFFF_FFF8);
        cyc(); #1 check32("wr_addr2", mem_addr, 32'hFFFF_FFFC);
        cyc(); #1;
        check32("wr_addr3", mem_addr, 32'h0);
        check32("wr_pc1", ins_pc, 32'hFFFF_FFF8);
        check32("wr_data1", ins_data, 32'h5A5A_FFF8);
        cyc(); #1;
        check32("wr_pc2", ins_pc, 32'hFFFF_FFFC);
        check32("wr_data2", ins_data, 32'h5A5A_FFFC);
        cyc(); #1;
        check32("wr_pc3", ins_pc, 32'h0);
        check32("wr_data3", ins_data, 32'hA5A5_0000);
        repeat (2) cyc();

        // Halt with two buffered words and one in flight
        ins_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
        cyc();
        redirect = 1'b0;
        #1 check32("h_addr0", mem_addr, 32'h200);
        cyc(); #1 check32("h_addr1", mem_addr, 32'h204);
        cyc(); #1;
        check32("h_cnt1", 32'(count), 32'd1);
        check32("h_addr2", mem_addr, 32'h208);
        cyc();
        halt = 1'b1;
        #1;
        check32("h_cnt2", 32'(count), 32'd2);
        check1("h_req_off", mem_req, 1'b0);
        cyc(); #1;
        check32("h_cnt3", 32'(count), 32'd3);
        check1("h_req_off2", mem_req, 1'b0);
        check32("h_pc0", ins_pc, 32'h200);
        ins_ready = 1'b1;
        cyc(); #1 check32("h_pc1", ins_pc, 32'h204);
        cyc(); #1 check32("h_pc2", ins_pc, 32'h208);
        cyc(); #1;
        check1("h_drained", ins_valid, 1'b0);
        check1("h_req_off3", mem_req, 1'b0);
        halt = 1'b0;
        #1;
        check1("h_resume_req", mem_req, 1'b1);
        check32("h_resume_addr", mem_addr, 32'h20C);
        repeat (3) cyc();

        // Redirect while halted
        halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
        #1 check1("hr_req", mem_req, 1'b0);
        cyc();
        redirect = 1'b0;
        #1;
        check1("hr_req1", mem_req, 1'b0);
        check32("hr_count", 32'(count), 32'd0);
        cyc();
        halt = 1'b0;
        #1;
        check1("hr_req2", mem_req, 1'b1);
        check32("hr_addr2", mem_addr, 32'h300);
        repeat (3) cyc();

        // Asynchronous reset with three buffered words
        ins_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h400;
        cyc();
        redirect = 1'b0;
        repeat (4) cyc();
        #1 check32("ar_count3", 32'(count), 32'd3);
        rst_n = 1'b0;
        #1;
        check1("ar_vld", ins_valid, 1'b0);
        check32("ar_count", 32'(count), 32'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        #1;
        check1("ar_req", mem_req, 1'b1);
        check32("ar_addr", mem_addr, RESET_PC);
        cyc(); #1 check32("ar_addr1", mem_addr, RESET_PC + 32'd4);
        repeat (4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
